// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-to-system-bus bridge.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } bridge_state_t;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cpu_bus_wait_timer.sv
// Loadable saturating up/down counter used for latency countdown and ack timeout.
module cpu_bus_wait_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_up,
  input  logic [Width-1:0] i_limit,
  output logic             o_zero,
  output logic             o_at_limit
);

  logic [Width-1:0] r_count;

  // Saturates at zero going down and at i_limit going up, so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      if (i_up) begin
        if (r_count != i_limit) r_count <= r_count + 1'b1;
      end else begin
        if (r_count != '0) r_count <= r_count - 1'b1;
      end
    end
  end

  always_comb begin
    o_zero     = (r_count == '0);
    o_at_limit = (r_count == i_limit);
  end

endmodule

// File: rtl/cpu_bus_bridge.sv
// Bridge from a valid/ready CPU memory port to the single-cycle-strobe system bus,
// with fixed-latency or acknowledge/timeout completion.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int unsigned address_width = 32,
  parameter int unsigned data_width    = 32,
  parameter int unsigned UseAck        = 0,
  parameter int unsigned ReadLatency   = 1,
  parameter int unsigned WriteLatency  = 1,
  parameter int unsigned TimeoutCycles = 16,
  parameter logic [31:0] TimeoutData   = TIMEOUT_DATA_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      mem_valid_i,
  input  logic [address_width-1:0]  mem_addr_i,
  input  logic [data_width-1:0]     mem_wdata_i,
  input  logic [data_width/8-1:0]   mem_wstrb_i,
  output logic [data_width-1:0]     mem_rdata_o,
  output logic                      mem_ready_o,
  output logic [address_width-1:0]  address_o,
  output logic [data_width-1:0]     data_o,
  input  logic [data_width-1:0]     data_i,
  output logic                      we_o,
  output logic [data_width/8-1:0]   we_ram_o,
  input  logic                      ack_i,
  output logic                      timeout_o,
  output logic                      busy_o
);

  localparam int unsigned SW     = data_width / 8;
  localparam int unsigned CntMax = max3(ReadLatency, WriteLatency, TimeoutCycles);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam bit          AckMode = (UseAck != 0);

  localparam logic [CntW-1:0]       RdLat  = CntW'(ReadLatency);
  localparam logic [CntW-1:0]       WrLat  = CntW'(WriteLatency);
  localparam logic [CntW-1:0]       ToLim  = CntW'(TimeoutCycles);
  localparam logic [data_width-1:0] ToData = data_width'(TimeoutData);

  bridge_state_t r_state, w_next;

  logic [address_width-1:0] r_addr;
  logic [data_width-1:0]    r_wdata;
  logic [SW-1:0]            r_wstrb;
  logic [data_width-1:0]    r_rdata;
  logic                     r_timeout;

  logic            w_capture;
  logic            w_sample;
  logic            w_take_to;
  logic            w_is_write;
  logic            w_cnt_en;
  logic [CntW-1:0] w_load_val;
  logic            w_zero;
  logic            w_at_limit;

  assign w_is_write = |r_wstrb;

  // Fixed mode counts the latency down to zero; ack mode counts up toward the timeout.
  always_comb begin
    w_load_val = '0;
    if (!AckMode) w_load_val = (|mem_wstrb_i) ? WrLat : RdLat;
    w_cnt_en = (r_state == ISSUE) || (r_state == WAIT);
  end

  cpu_bus_wait_timer #(
    .Width(CntW)
  ) u_timer (
    .i_clk      (clk_i),
    .i_reset    (reset_i),
    .i_load     (w_capture),
    .i_load_val (w_load_val),
    .i_en       (w_cnt_en),
    .i_up       (AckMode),
    .i_limit    (ToLim),
    .o_zero     (w_zero),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_sample  = 1'b0;
    w_take_to = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (mem_valid_i) begin
          w_capture = 1'b1;
          w_next    = ISSUE;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (AckMode) begin
          // Ack takes priority over a timeout in the same cycle.
          if (ack_i) begin
            w_sample = 1'b1;
            w_next   = RESP;
          end else if (w_at_limit) begin
            w_take_to = 1'b1;
            w_next    = RESP;
          end
        end else if (w_zero) begin
          w_sample = 1'b1;
          w_next   = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr    <= mem_addr_i;
        r_wdata   <= mem_wdata_i;
        r_wstrb   <= mem_wstrb_i;
        r_timeout <= 1'b0;
      end
      if (w_sample && !w_is_write) r_rdata <= data_i;
      if (w_take_to) begin
        r_timeout <= 1'b1;
        if (!w_is_write) r_rdata <= ToData;
      end
    end
  end

  always_comb begin
    address_o   = (r_state == ISSUE) ? r_addr : '0;
    we_ram_o    = (r_state == ISSUE) ? r_wstrb : '0;
    we_o        = (r_state == ISSUE) && w_is_write;
    mem_ready_o = (r_state == RESP);
    timeout_o   = (r_state == RESP) && r_timeout;
    busy_o      = (r_state != IDLE);
    data_o      = r_wdata;
    mem_rdata_o = r_rdata;
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Scoreboard bench: DUT 0 runs fixed latency (read 3, write 1), DUT 1 runs ack mode
// with a 16-cycle timeout; expected responses come from a cycle-level transaction model.
module tb_cpu_bus_bridge;

  localparam int A_RL = 3;
  localparam int A_WL = 1;
  localparam int B_TO = 16;
  localparam logic [31:0] SALT_A = 32'h1357_9BDF;
  localparam logic [31:0] SALT_B = 32'h2468_ACE0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    bit          to;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } strobe_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst   [2];
  logic        valid [2];
  logic        ready [2];
  logic        we    [2];
  logic        tmo   [2];
  logic        busy  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [31:0] bus_addr [2];
  logic [31:0] data_o [2];
  logic [3:0]  wstrb [2];
  logic [3:0]  we_ram [2];
  logic [31:0] last  [2];

  logic [31:0] data_i_a, data_i_b;
  logic        ack_a, ack_b;

  int b_t = -100;
  int b_k = 0;
  bit b_noise = 1'b0;

  resp_t   rq [2][$];
  strobe_t sq [2][$];

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] dgen(input int c, input logic [31:0] salt);
    return (32'(c) * 32'h9E37_79B1) ^ salt;
  endfunction

  assign data_i_a = dgen(cyc, SALT_A);
  assign data_i_b = dgen(cyc, SALT_B);
  assign ack_b    = (cyc == b_t && b_noise) || (cyc == b_t + b_k);
  always @(posedge clk) ack_a <= ($urandom & 1) != 0;

  cpu_bus_bridge #(
    .UseAck(0), .ReadLatency(A_RL), .WriteLatency(A_WL), .TimeoutCycles(B_TO)
  ) u_dut_a (
    .clk_i(clk), .reset_i(rst[0]), .mem_valid_i(valid[0]), .mem_addr_i(addr[0]),
    .mem_wdata_i(wdata[0]), .mem_wstrb_i(wstrb[0]), .mem_rdata_o(rdata[0]),
    .mem_ready_o(ready[0]), .address_o(bus_addr[0]), .data_o(data_o[0]),
    .data_i(data_i_a), .we_o(we[0]), .we_ram_o(we_ram[0]), .ack_i(ack_a),
    .timeout_o(tmo[0]), .busy_o(busy[0])
  );

  cpu_bus_bridge #(
    .UseAck(1), .ReadLatency(1), .WriteLatency(1), .TimeoutCycles(B_TO)
  ) u_dut_b (
    .clk_i(clk), .reset_i(rst[1]), .mem_valid_i(valid[1]), .mem_addr_i(addr[1]),
    .mem_wdata_i(wdata[1]), .mem_wstrb_i(wstrb[1]), .mem_rdata_o(rdata[1]),
    .mem_ready_o(ready[1]), .address_o(bus_addr[1]), .data_o(data_o[1]),
    .data_i(data_i_b), .we_o(we[1]), .we_ram_o(we_ram[1]), .ack_i(ack_b),
    .timeout_o(tmo[1]), .busy_o(busy[1])
  );

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic check_all_zero(input int d, input string tag);
    check({tag, "_rdata"}, d, rdata[d], 32'h0);
    check({tag, "_ready"}, d, 32'(ready[d]), 32'h0);
    check({tag, "_address"}, d, bus_addr[d], 32'h0);
    check({tag, "_data_o"}, d, data_o[d], 32'h0);
    check({tag, "_we"}, d, 32'(we[d]), 32'h0);
    check({tag, "_we_ram"}, d, 32'(we_ram[d]), 32'h0);
    check({tag, "_timeout"}, d, 32'(tmo[d]), 32'h0);
    check({tag, "_busy"}, d, 32'(busy[d]), 32'h0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      resp_t   e;
      strobe_t s;
      if (ready[d] === 1'b1) begin
        if (rq[d].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ready dut%0d cycle %0d: got 1 expected 0", d, cyc);
        end else begin
          e = rq[d].pop_front();
          check("ready_cycle", d, 32'(cyc), 32'(e.cyc));
          check("rdata", d, rdata[d], e.rdata);
          check("timeout", d, 32'(tmo[d]), 32'(e.to));
        end
      end else if (tmo[d] === 1'b1) begin
        check("timeout_without_ready", d, 32'(tmo[d]), 32'h0);
      end
      if (bus_addr[d] != 32'h0 || we[d] === 1'b1 || we_ram[d] != 4'h0) begin
        if (sq[d].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe dut%0d cycle %0d: got addr %h expected none",
                   d, cyc, bus_addr[d]);
        end else begin
          s = sq[d].pop_front();
          check("strobe_cycle", d, 32'(cyc), 32'(s.cyc));
          check("address", d, bus_addr[d], s.addr);
          check("we", d, 32'(we[d]), 32'(|s.wstrb));
          check("we_ram", d, 32'(we_ram[d]), 32'(s.wstrb));
          check("data_o", d, data_o[d], s.wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input int d, input bit is_wr, output strobe_t s);
    addr[d] = $urandom;
    if (addr[d] == 32'h0) addr[d] = 32'h10;
    wdata[d] = $urandom;
    wstrb[d] = is_wr ? 4'($urandom_range(1, 15)) : 4'h0;
    valid[d] = 1'b1;
    s.cyc   = cyc + 1;
    s.addr  = addr[d];
    s.wdata = wdata[d];
    s.wstrb = wstrb[d];
    sq[d].push_back(s);
  endtask

  // Called in a cycle where the DUT is idle; returns in the cycle after mem_ready_o.
  task automatic txn(input int d, input bit is_wr, input int k);
    strobe_t s;
    resp_t   r;
    int      t;
    int      lat;
    bit      got;
    start_req(d, is_wr, s);
    t = s.cyc;
    if (d == 0) begin
      lat     = is_wr ? A_WL : A_RL;
      r.cyc   = t + lat + 1;
      r.rdata = is_wr ? last[0] : dgen(t + lat, SALT_A);
      r.to    = 1'b0;
    end else begin
      b_t     = t;
      b_k     = k;
      b_noise = ($urandom & 1) != 0;
      if (k <= B_TO) begin
        r.cyc   = t + k + 1;
        r.rdata = is_wr ? last[1] : dgen(t + k, SALT_B);
        r.to    = 1'b0;
      end else begin
        r.cyc   = t + B_TO + 1;
        r.rdata = is_wr ? last[1] : 32'hDEAD_BEEF;
        r.to    = 1'b1;
      end
    end
    last[d] = r.rdata;
    rq[d].push_back(r);
    step();
    addr[d]  = $urandom;
    wdata[d] = $urandom;
    wstrb[d] = 4'($urandom);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ready[d] === 1'b1) got = 1'b1;
      else step();
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout dut%0d cycle %0d: got no ready expected ready", d, cyc);
    end
    step();
    valid[d] = 1'b0;
  endtask

  task automatic reset_mid();
    strobe_t s;
    start_req(0, 1'b0, s);
    step();
    step();
    rst[0]   = 1'b1;
    valid[0] = 1'b0;
    step();
    rst[0] = 1'b0;
    check_all_zero(0, "midreset");
    last[0] = 32'h0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; valid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      last[d] = '0;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) check_all_zero(d, "reset");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();

    for (int i = 0; i < 40; i++) begin
      if (i == 20) reset_mid();
      txn(0, ($urandom & 1) != 0, 0);
      repeat ($urandom_range(0, 2)) step();
    end

    for (int i = 0; i < 40; i++) begin
      int k;
      case (i % 8)
        0:       k = 17;
        1:       k = 16;
        2:       k = 1;
        default: k = $urandom_range(1, 17);
      endcase
      txn(1, ($urandom & 1) != 0, k);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (5) step();
    for (int d = 0; d < 2; d++) begin
      check("pending_responses", d, 32'(rq[d].size()), 32'h0);
      check("pending_strobes", d, 32'(sq[d].size()), 32'h0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bridge.md
# cpu_bus_bridge

Parametrised bridge between a native valid/ready CPU memory port (picorv32-style) and the single-cycle-strobe system bus. It supports configurable address/data widths, fixed read/write latencies or acknowledge-driven completion with a timeout. It sits between the CPU core and the system bus decoder, and is the next-generation replacement for the fixed one-cycle CPU wrapper handshake.

## Interface
- address_width, 32: bus and CPU address width
- data_width, 32: data width; multiple of 8; strobe width SW = data_width/8
- UseAck, 0: 0 = fixed-latency completion; 1 = completion on ack_i
- ReadLatency, 1: fixed mode, cycles from ISSUE to valid data_i (1..15)
- WriteLatency, 1: fixed mode, cycles from ISSUE to write completion (1..15)
- TimeoutCycles, 16: ack mode, WAIT cycles before forced completion (1..255)
- TimeoutData, 32'hDEAD_BEEF: read data returned on timeout, zero-extended or truncated to data_width
- Clock/reset: single clock; reset synchronous, active-high.
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- mem_valid_i  in  1  CPU request valid
- mem_addr_i  in  address_width  CPU address
- mem_wdata_i  in  data_width  CPU write data
- mem_wstrb_i  in  SW  byte strobes; all zero = read
- mem_rdata_o  out  data_width  registered read data
- mem_ready_o  out  1  one-cycle completion pulse
- address_o  out  address_width  bus address; nonzero only in ISSUE
- data_o  out  data_width  bus write data
- data_i  in  data_width  bus read data
- we_o  out  1  write pulse
- we_ram_o  out  SW  byte enables
- ack_i  in  1  bus acknowledge (ignored when UseAck=0)
- timeout_o  out  1  one-cycle pulse on timed-out completion
- busy_o  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when mem_valid_i=1, capture address, wdata and wstrb; load the counter; go to ISSUE.
- ISSUE (one cycle): address_o = captured address; we_ram_o = captured wstrb; we_o = |wstrb. Go to WAIT.
- WAIT, fixed mode: the counter is loaded with L (ReadLatency for a read, WriteLatency for a write). It decrements each cycle from ISSUE. At zero, register data_i into mem_rdata_o (reads only) and go to RESP.
- WAIT, ack mode: the counter counts up. On ack_i=1, register data_i (reads) and go to RESP. On count = TimeoutCycles without ack, mem_rdata_o = TimeoutData (reads), set the timeout flag, and go to RESP. If ack_i and timeout occur in the same cycle, ack wins.
- ack_i is ignored in IDLE, ISSUE and RESP.
- RESP: mem_ready_o=1 and timeout_o = flag, both for exactly one cycle; then go to IDLE.
- mem_rdata_o holds its value until the next read completes. Writes leave it unchanged.
- data_o is the registered captured wdata and holds between transactions.
- CPU inputs that change after capture are ignored. The requester drops mem_valid_i in the cycle after mem_ready_o. IDLE accepts a new request in that cycle or any later cycle.
- Reset in any state aborts the transaction: no mem_ready_o and no bus strobe is issued.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- mem_valid_i rises in cycle t-1 (IDLE); ISSUE occurs in cycle t.
- Fixed mode: data_i is sampled in cycle t+L; mem_ready_o is high in cycle t+L+1. Total latency from mem_valid_i is L+2 cycles.
- Ack mode: ack_i is sampled in cycle t+k (k≥1); mem_ready_o is high in cycle t+k+1.
- Ack mode timeout: mem_ready_o and timeout_o are high in cycle t+TimeoutCycles+1.
- address_o, we_o and we_ram_o are high or nonzero only in cycle t.
- Counter width = $clog2(max(ReadLatency, WriteLatency, TimeoutCycles)+1). The counter never wraps.

## Structure
- Package cpu_bus_pkg: bridge_state_t enum (IDLE, ISSUE, WAIT, RESP) and the default TimeoutData constant.
- One sub-module, cpu_bus_wait_timer: a loadable up/down counter with load, enable, direction and terminal-count outputs.
- The FSM and capture registers live in cpu_bus_bridge.

## Test plan
- Fixed mode, L=1: read 0x0000_1000 with data_i=0x1234_5678 at t+1 -> address_o=0x1000 only at t; mem_ready_o at t+2; mem_rdata_o=0x1234_5678.
- Write 0xAABB_CCDD, wstrb=0011 -> at t: we_o=1, we_ram_o=0011, data_o=0xAABB_CCDD; mem_ready_o at t+WriteLatency+1; mem_rdata_o unchanged.
- ReadLatency=3, data_i = 1, 2, 3 at t+1..t+3 -> mem_ready_o at t+4; mem_rdata_o=3.
- UseAck=1, ack_i at t+5 with data_i=0x55 -> mem_ready_o at t+6; rdata=0x55; timeout_o=0. Also: ack_i held high in ISSUE only -> ignored.
- UseAck=1, TimeoutCycles=16, no ack -> mem_ready_o and timeout_o at t+17; rdata=0xDEAD_BEEF; the next transaction completes normally.
- reset_i pulsed at t+1 of an L=3 read -> next cycle all outputs 0; no mem_ready_o; a following request completes in L+2 cycles.
